// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths and the EX/MEM control bundle,
// reused by the earlier pipeline registers.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct packed {
    logic            MemRead;
    logic            MemWrite;
    logic            MemtoReg;
    logic            RegWrite;
    logic [RA_W-1:0] rd_waddr;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/branch_resolve.sv
// Pure combinational branch/jump resolution from the execute-stage ALU flags.
module branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            i_Jump,
  input  logic            i_jalr,
  input  logic            i_BranchEqual,
  input  logic            i_BranchLT,
  input  logic            i_br_invert,
  input  logic            i_eq,
  input  logic            i_slt,
  input  logic [XLEN-1:0] i_result,
  input  logic [XLEN-1:0] i_target,
  output logic            o_taken,
  output logic [XLEN-1:0] o_tgt,
  output logic            o_misaligned
);

  logic cmp;

  // funct3[0] flips beq->bne and blt->bge, so one XOR covers both pairs.
  assign cmp          = (i_BranchEqual & (i_eq  ^ i_br_invert))
                      | (i_BranchLT    & (i_slt ^ i_br_invert));
  assign o_taken      = i_Jump | cmp;
  assign o_tgt        = i_jalr ? {i_result[XLEN-1:1], 1'b0} : i_target;
  assign o_misaligned = o_taken & (o_tgt[1:0] != 2'b00);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves control flow, registers EX results and
// raises a one-shot redirect from registered state only.
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_result,
  input  logic            i_eq,
  input  logic            i_slt,
  input  logic [XLEN-1:0] i_target,
  input  logic [XLEN-1:0] i_PC4,
  input  logic [XLEN-1:0] i_uimm,
  input  logic [XLEN-1:0] i_reg2,
  input  logic            i_Jump,
  input  logic            i_jalr,
  input  logic            i_BranchEqual,
  input  logic            i_BranchLT,
  input  logic            i_br_invert,
  input  logic            i_MemRead,
  input  logic            i_MemWrite,
  input  logic            i_MemtoReg,
  input  logic            i_RegWrite,
  input  logic            i_IsUInstruct,
  input  logic [RA_W-1:0] i_rd_waddr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_store_data,
  output logic [XLEN-1:0] o_wb_data,
  output logic [RA_W-1:0] o_rd_waddr,
  output logic            o_RegWrite,
  output logic            o_MemRead,
  output logic            o_MemWrite,
  output logic            o_MemtoReg,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_misaligned
);

  import cpu_pkg::*;

  logic            ex_taken;
  logic            ex_mis;
  logic [XLEN-1:0] ex_tgt;
  logic [XLEN-1:0] ex_wb;
  ex_mem_ctrl_t    ex_ctrl;
  logic            load;

  logic            valid_q,  valid_d;
  logic            taken_q,  taken_d;
  logic            mis_q,    mis_d;
  logic            done_q,   done_d;
  logic [XLEN-1:0] tgt_q,    tgt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] store_q,  store_d;
  logic [XLEN-1:0] wb_q,     wb_d;
  ex_mem_ctrl_t    ctrl_q,   ctrl_d;

  branch_resolve #(.XLEN(XLEN)) u_branch_resolve (
    .i_Jump        (i_Jump),
    .i_jalr        (i_jalr),
    .i_BranchEqual (i_BranchEqual),
    .i_BranchLT    (i_BranchLT),
    .i_br_invert   (i_br_invert),
    .i_eq          (i_eq),
    .i_slt         (i_slt),
    .i_result      (i_result),
    .i_target      (i_target),
    .o_taken       (ex_taken),
    .o_tgt         (ex_tgt),
    .o_misaligned  (ex_mis)
  );

  assign load    = ~i_stall;
  assign ex_wb   = i_Jump ? i_PC4 : (i_IsUInstruct ? i_uimm : i_result);
  assign ex_ctrl = '{MemRead:  i_MemRead,  MemWrite: i_MemWrite,
                     MemtoReg: i_MemtoReg, RegWrite: i_RegWrite,
                     rd_waddr: i_rd_waddr};

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block infers a latch.
    valid_d  = valid_q;
    taken_d  = taken_q;
    mis_d    = mis_q;
    done_d   = done_q;
    tgt_d    = tgt_q;
    result_d = result_q;
    store_d  = store_q;
    wb_d     = wb_q;
    ctrl_d   = ctrl_q;
    if (load) begin
      // Whatever sits in EX while we redirect is wrong-path: capture it as a bubble.
      valid_d  = i_valid & ~o_redirect;
      taken_d  = ex_taken;
      mis_d    = ex_mis;
      tgt_d    = ex_tgt;
      result_d = i_result;
      store_d  = i_reg2;
      wb_d     = ex_wb;
      ctrl_d   = ex_ctrl;
      done_d   = 1'b0;
    end else if (o_redirect) begin
      done_d = 1'b1;
    end
    // Flush beats stall: only the valid bit drops, payload stays put.
    if (i_flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      mis_q    <= 1'b0;
      done_q   <= 1'b0;
      tgt_q    <= '0;
      result_q <= '0;
      store_q  <= '0;
      wb_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      valid_q  <= valid_d;
      taken_q  <= taken_d;
      mis_q    <= mis_d;
      done_q   <= done_d;
      tgt_q    <= tgt_d;
      result_q <= result_d;
      store_q  <= store_d;
      wb_q     <= wb_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign o_redirect    = valid_q & taken_q & ~mis_q & ~done_q;
  assign o_redirect_pc = tgt_q;
  assign o_misaligned  = valid_q & taken_q & mis_q;
  assign o_valid       = valid_q;
  assign o_result      = result_q;
  assign o_store_data  = store_q;
  assign o_wb_data     = wb_q;
  assign o_rd_waddr    = ctrl_q.rd_waddr;
  assign o_RegWrite    = valid_q & ctrl_q.RegWrite;
  assign o_MemRead     = valid_q & ctrl_q.MemRead;
  assign o_MemWrite    = valid_q & ctrl_q.MemWrite;
  assign o_MemtoReg    = ctrl_q.MemtoReg;

endmodule
